// File: rtl/param_fifo_pkg.sv
// Shared defaults and helpers for the parametrised single-clock FIFO.
package param_fifo_pkg;

  localparam int FIFO_DEF_WIDTH = 8;
  localparam int FIFO_DEF_DEPTH = 8;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap so non-power-of-two depths never index past the last slot.
  function automatic int ptr_next(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/param_fifo_mem.sv
// WIDTH x DEPTH register array: one write port, one registered read port.
module param_fifo_mem #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // A same-edge write to raddr is not visible here: the read returns the old word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_o <= '0;
    else if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with occupancy count and programmable almost flags.
// Optional sticky overflow/underflow flags are enabled by defining PARAM_FIFO_ERR_FLAGS_EN.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter  int WIDTH    = FIFO_DEF_WIDTH,
  parameter  int DEPTH    = FIFO_DEF_DEPTH,
  parameter  int AF_LEVEL = DEPTH - 1,
  parameter  int AE_LEVEL = 1,
  localparam int CW       = cnt_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wn,
  input  logic             rn,
  input  logic [WIDTH-1:0] DATAIN,
  output logic [WIDTH-1:0] DATAOUT,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count
`ifdef PARAM_FIFO_ERR_FLAGS_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ok, rd_ok;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  always_comb begin
    wr_ok    = wn & (~full | rn);
    rd_ok    = rn & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = PW'(ptr_next(int'(wr_ptr_q), DEPTH));
    if (rd_ok) rd_ptr_d = PW'(ptr_next(int'(rd_ptr_q), DEPTH));
    if (wr_ok && !rd_ok)      count_d = count_q + CW'(1);
    else if (rd_ok && !wr_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  param_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clock),
    .rst_ni  (reset),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (DATAIN),
    .re_i    (rd_ok),
    .raddr_i (rd_ptr_q),
    .rdata_o (DATAOUT)
  );

`ifdef PARAM_FIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wn && !wr_ok) ovf_q <= 1'b1;
      if (rn && empty)  unf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  // Rejected operations are dropped without any record.
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Randomised and directed bench for param_fifo against a queue-based reference model.
module tb_param_fifo;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        wn8 = 1'b0, rn8 = 1'b0;
  logic [7:0]  din8 = '0, dout8;
  logic        full8, empty8, af8, ae8;
  logic [3:0]  count8;

  logic        wn5 = 1'b0, rn5 = 1'b0;
  logic [15:0] din5 = '0, dout5;
  logic        full5, empty5, af5, ae5;
  logic [2:0]  count5;

`ifdef PARAM_FIFO_ERR_FLAGS_EN
  logic ovf8, unf8, ovf5, unf5;
`endif

  always #5 clock = ~clock;

  param_fifo #(.WIDTH(8), .DEPTH(8)) u8 (
    .clock(clock), .reset(reset), .wn(wn8), .rn(rn8), .DATAIN(din8), .DATAOUT(dout8),
    .full(full8), .empty(empty8), .almost_full(af8), .almost_empty(ae8), .count(count8)
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    , .overflow(ovf8), .underflow(unf8)
`endif
  );

  param_fifo #(.WIDTH(16), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2)) u5 (
    .clock(clock), .reset(reset), .wn(wn5), .rn(rn5), .DATAIN(din5), .DATAOUT(dout5),
    .full(full5), .empty(empty5), .almost_full(af5), .almost_empty(ae5), .count(count5)
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    , .overflow(ovf5), .underflow(unf5)
`endif
  );

  // Reference model: a queue of stored words plus the last word read out.
  logic [7:0]  m8_q[$];
  logic [7:0]  m8_dout;
  bit          m8_ovf, m8_unf;
  logic [15:0] m5_q[$];
  logic [15:0] m5_dout;
  bit          m5_ovf, m5_unf;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic model_reset();
    m8_q.delete(); m8_dout = '0; m8_ovf = 0; m8_unf = 0;
    m5_q.delete(); m5_dout = '0; m5_ovf = 0; m5_unf = 0;
  endtask

  task automatic step8(input logic w, input logic r, input logic [7:0] d);
    bit f, e, wok, rok;
    wn8 = w; rn8 = r; din8 = d;
    f   = (m8_q.size() == 8);
    e   = (m8_q.size() == 0);
    wok = w && (!f || r);
    rok = r && !e;
    if (w && !wok) m8_ovf = 1;
    if (r && e)    m8_unf = 1;
    @(posedge clock);
    if (rok) m8_dout = m8_q.pop_front();
    if (wok) m8_q.push_back(d);
    #1;
    wn8 = 1'b0; rn8 = 1'b0;
  endtask

  task automatic step5(input logic w, input logic r, input logic [15:0] d);
    bit f, e, wok, rok;
    wn5 = w; rn5 = r; din5 = d;
    f   = (m5_q.size() == 5);
    e   = (m5_q.size() == 0);
    wok = w && (!f || r);
    rok = r && !e;
    if (w && !wok) m5_ovf = 1;
    if (r && e)    m5_unf = 1;
    @(posedge clock);
    if (rok) m5_dout = m5_q.pop_front();
    if (wok) m5_q.push_back(d);
    #1;
    wn5 = 1'b0; rn5 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_chk++; if (count8 !== 4'd0) $display("FAIL reset_count8 got %0d want 0", count8); else n_pass++;
    n_chk++; if ({empty8, full8, af8, ae8} !== 4'b1001) $display("FAIL reset_flags8 got %b want 1001", {empty8, full8, af8, ae8}); else n_pass++;
    n_chk++; if (dout8 !== 8'd0) $display("FAIL reset_dout8 got %0d want 0", dout8); else n_pass++;
    n_chk++; if ({count5, empty5, full5, af5, ae5} !== 7'b000_1001) $display("FAIL reset_state5 got %b want 0001001", {count5, empty5, full5, af5, ae5}); else n_pass++;
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    n_chk++; if ({ovf8, unf8} !== 2'b00) $display("FAIL reset_err8 got %b want 00", {ovf8, unf8}); else n_pass++;
`endif
  endtask

  task automatic test_basic();
    logic [7:0] vals [7] = '{8'd100, 8'd150, 8'd200, 8'd40, 8'd70, 8'd65, 8'd15};
    for (int i = 0; i < 7; i++) step8(1'b1, 1'b0, vals[i]);
    n_chk++; if (count8 !== 4'd7) $display("FAIL basic_count got %0d want 7", count8); else n_pass++;
    n_chk++; if ({af8, full8, empty8} !== 3'b100) $display("FAIL basic_flags got %b want 100", {af8, full8, empty8}); else n_pass++;
    for (int i = 0; i < 7; i++) begin
      step8(1'b0, 1'b1, 8'd0);
      n_chk++; if (dout8 !== vals[i]) $display("FAIL basic_read%0d got %0d want %0d", i, dout8, vals[i]); else n_pass++;
    end
    n_chk++; if ({empty8, count8} !== 5'b1_0000) $display("FAIL basic_drained got empty=%b count=%0d want empty=1 count=0", empty8, count8); else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) step8(1'b1, 1'b0, 8'(i));
    step8(1'b1, 1'b0, 8'd99);
    n_chk++; if ({full8, count8} !== 5'b1_1000) $display("FAIL ovf_full got full=%b count=%0d want full=1 count=8", full8, count8); else n_pass++;
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    n_chk++; if (ovf8 !== 1'b1) $display("FAIL ovf_flag got %b want 1", ovf8); else n_pass++;
`endif
    for (int i = 1; i <= 8; i++) begin
      step8(1'b0, 1'b1, 8'd0);
      n_chk++; if (dout8 !== 8'(i)) $display("FAIL ovf_drain%0d got %0d want %0d", i, dout8, i); else n_pass++;
    end
    step8(1'b0, 1'b1, 8'd0);
    n_chk++; if ({dout8, empty8} !== {8'd8, 1'b1}) $display("FAIL unf_hold got dout=%0d empty=%b want dout=8 empty=1", dout8, empty8); else n_pass++;
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    n_chk++; if (unf8 !== 1'b1) $display("FAIL unf_flag got %b want 1", unf8); else n_pass++;
`endif
  endtask

  task automatic test_full_rw();
    for (int i = 1; i <= 8; i++) step8(1'b1, 1'b0, 8'(i + 10));
    step8(1'b1, 1'b1, 8'd55);
    n_chk++; if ({dout8, count8} !== {8'd11, 4'd8}) $display("FAIL fullrw_pop got dout=%0d count=%0d want dout=11 count=8", dout8, count8); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      step8(1'b0, 1'b1, 8'd0);
      n_chk++; if (dout8 !== m8_dout) $display("FAIL fullrw_drain%0d got %0d want %0d", i, dout8, m8_dout); else n_pass++;
    end
    n_chk++; if (dout8 !== 8'd55) $display("FAIL fullrw_last got %0d want 55", dout8); else n_pass++;
  endtask

  task automatic test_empty_rw();
    logic [7:0] prev;
    prev = dout8;
    step8(1'b1, 1'b1, 8'd7);
    n_chk++; if ({dout8, count8, empty8} !== {prev, 4'd1, 1'b0}) $display("FAIL emptyrw got dout=%0d count=%0d empty=%b want dout=%0d count=1 empty=0", dout8, count8, empty8, prev); else n_pass++;
    step8(1'b0, 1'b1, 8'd0);
    n_chk++; if (dout8 !== 8'd7) $display("FAIL emptyrw_read got %0d want 7", dout8); else n_pass++;
  endtask

  task automatic test_wrap5();
    logic [15:0] exp;
    for (int i = 1; i <= 3; i++) step5(1'b1, 1'b0, 16'(i * 16'h1111));
    for (int i = 1; i <= 3; i++) begin
      step5(1'b0, 1'b1, 16'd0);
      n_chk++; if (dout5 !== 16'(i * 16'h1111)) $display("FAIL wrap_first%0d got %h want %h", i, dout5, 16'(i * 16'h1111)); else n_pass++;
    end
    for (int i = 1; i <= 4; i++) step5(1'b1, 1'b0, 16'hA000 + 16'(i));
    n_chk++; if ({count5, af5, ae5} !== 5'b100_10) $display("FAIL wrap_level got %b want 10010", {count5, af5, ae5}); else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      step5(1'b0, 1'b1, 16'd0);
      exp = 16'hA000 + 16'(i);
      n_chk++; if (dout5 !== exp) $display("FAIL wrap_second%0d got %h want %h", i, dout5, exp); else n_pass++;
    end
  endtask

  task automatic test_reset_pulse();
    for (int i = 0; i < 4; i++) step8(1'b1, 1'b0, 8'(200 + i));
    step8(1'b0, 1'b1, 8'd0);
    step8(1'b1, 1'b0, 8'd250);
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_chk++; if ({count8, empty8, dout8} !== {4'd0, 1'b1, 8'd0}) $display("FAIL pulse_state got count=%0d empty=%b dout=%0d want 0 1 0", count8, empty8, dout8); else n_pass++;
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    n_chk++; if ({ovf8, unf8} !== 2'b00) $display("FAIL pulse_err got %b want 00", {ovf8, unf8}); else n_pass++;
`endif
    #2 reset = 1'b1;
    step8(1'b1, 1'b0, 8'd42);
    step8(1'b0, 1'b1, 8'd0);
    n_chk++; if ({dout8, empty8} !== {8'd42, 1'b1}) $display("FAIL pulse_after got dout=%0d empty=%b want 42 1", dout8, empty8); else n_pass++;
  endtask

  task automatic test_random();
    int wp;
    for (int i = 0; i < 300; i++) begin
      wp = ((i / 40) % 2 == 0) ? 75 : 25;
      step8($urandom_range(99, 0) < wp, $urandom_range(99, 0) < 100 - wp, 8'($urandom));
      n_chk++; if (count8 !== 4'(m8_q.size())) $display("FAIL rnd8_count@%0d got %0d want %0d", i, count8, m8_q.size()); else n_pass++;
      n_chk++; if (dout8 !== m8_dout) $display("FAIL rnd8_dout@%0d got %0d want %0d", i, dout8, m8_dout); else n_pass++;
      n_chk++; if ({full8, empty8, af8, ae8} !== {m8_q.size() == 8, m8_q.size() == 0, m8_q.size() >= 7, m8_q.size() <= 1})
        $display("FAIL rnd8_flags@%0d got %b for size %0d", i, {full8, empty8, af8, ae8}, m8_q.size()); else n_pass++;
`ifdef PARAM_FIFO_ERR_FLAGS_EN
      n_chk++; if ({ovf8, unf8} !== {m8_ovf, m8_unf}) $display("FAIL rnd8_err@%0d got %b want %b", i, {ovf8, unf8}, {m8_ovf, m8_unf}); else n_pass++;
`endif
    end
    for (int i = 0; i < 200; i++) begin
      wp = ((i / 30) % 2 == 0) ? 70 : 30;
      step5($urandom_range(99, 0) < wp, $urandom_range(99, 0) < 100 - wp, 16'($urandom));
      n_chk++; if (count5 !== 3'(m5_q.size())) $display("FAIL rnd5_count@%0d got %0d want %0d", i, count5, m5_q.size()); else n_pass++;
      n_chk++; if (dout5 !== m5_dout) $display("FAIL rnd5_dout@%0d got %h want %h", i, dout5, m5_dout); else n_pass++;
      n_chk++; if ({full5, empty5, af5, ae5} !== {m5_q.size() == 5, m5_q.size() == 0, m5_q.size() >= 3, m5_q.size() <= 2})
        $display("FAIL rnd5_flags@%0d got %b for size %0d", i, {full5, empty5, af5, ae5}, m5_q.size()); else n_pass++;
`ifdef PARAM_FIFO_ERR_FLAGS_EN
      n_chk++; if ({ovf5, unf5} !== {m5_ovf, m5_unf}) $display("FAIL rnd5_err@%0d got %b want %b", i, {ovf5, unf5}, {m5_ovf, m5_unf}); else n_pass++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_wrap5();
    test_reset_pulse();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
Parametrised synchronous single-clock FIFO. It is the next generation of the team's 8-bit fixed-depth jFIFO, generalised in WIDTH and DEPTH, and adds:
- occupancy count output
- programmable almost-full and almost-empty flags
- defined simultaneous read/write at the full and empty boundaries
- optional sticky overflow/underflow error flags

It sits between producer and consumer blocks in the same clock domain and keeps jFIFO's registered-read semantics.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of entries (>=2; any value, not only powers of two)
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
wn  in  1  write request
rn  in  1  read request
DATAIN  in  WIDTH  write data, sampled on an accepted write
DATAOUT  out  WIDTH  registered read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  $clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky error flag; present only with PARAM_FIFO_ERR_FLAGS_EN
underflow  out  1  sticky error flag; present only with PARAM_FIFO_ERR_FLAGS_EN

Behaviour:
- Reset (reset==0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, DATAOUT=0, empty=1, full=0, almost_full=0, almost_empty=1, overflow=0, underflow=0. Memory contents are not reset. Release is synchronous to clock.
- Accept rules, evaluated on the pre-edge state:
  - wr_ok = wn & (!full | rn)
  - rd_ok = rn & !empty
- Accepted write: mem[wr_ptr] <= DATAIN; wr_ptr advances.
- Accepted read: DATAOUT <= mem[rd_ptr] at the same edge (1-cycle latency from rn to valid DATAOUT); rd_ptr advances. DATAOUT holds its value when no read is accepted.
- Pointer wrap: DEPTH-1 -> 0 explicitly. No reliance on power-of-two overflow.
- count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Flags are combinational decodes of the registered count, so they are valid in the cycle after the edge that changed count.
- Full and rn=wn=1: both accepted. The write lands in the slot vacated by the read; count stays DEPTH.
- Empty and rn=wn=1: write accepted; read rejected (underflow event); DATAOUT unchanged; count becomes 1. No write-through bypass.
- Full and wn=1, rn=0: write dropped (overflow event); memory and pointers unchanged.
- Empty and rn=1, wn=0: nothing changes (underflow event).
- Reset asserted mid-burst: all state returns to reset values immediately; pending data is discarded.

Optional Feature:
Macro PARAM_FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow ports exist; overflow sets on any rejected write (wn & !wr_ok).
  - underflow ports exist; underflow sets on any rejected read (rn & empty).
  - Both flags are sticky until reset.
- Undefined: the overflow and underflow ports and their logic are absent. Rejected operations are silently ignored, with identical data-path behaviour.

Decomposition:
- Package param_fifo_pkg holds:
  - default constants FIFO_DEF_WIDTH=8 and FIFO_DEF_DEPTH=8
  - helper function cnt_width(depth) = $clog2(depth+1)
  - pointer-increment-with-wrap function
- One sub-module, param_fifo_mem: WIDTH x DEPTH register array with one write port (we, waddr, wdata) and one registered read port (re, raddr, rdata, async active-low reset of rdata to 0).
- The top level holds pointers, count, flags and error logic.

Test Plan:
- Reset, then write 100,150,200,40,70,65,15 (DEPTH=8) -> count=7, almost_full=1, full=0, empty=0; then read 7 times -> DATAOUT 100,150,200,40,70,65,15 in order, one cycle after each rn; after the last read, empty=1, count=0.
- Fill with 8 writes (1..8), then a 9th write of 99 -> full=1, count=8, 99 dropped, overflow=1 (with macro); drain -> DATAOUT 1..8; extra read -> DATAOUT stays 8, underflow=1.
- When full, wn=rn=1 with DATAIN=55 -> DATAOUT=oldest entry, count stays 8; drain shows 55 last.
- When empty, wn=rn=1 with DATAIN=7 -> DATAOUT unchanged, count=1, empty=0; next read -> DATAOUT=7.
- Wrap-around with DEPTH=5, WIDTH=16: 3 writes, 3 reads, 4 writes (0xA001..0xA004), 4 reads -> data in order, pointers wrapped, no corruption.
- Reset pulse (reset=0 for 3 ns, mid-cycle) while count=4 -> immediately count=0, empty=1, DATAOUT=0, overflow=underflow=0; a subsequent write/read of 42 -> DATAOUT=42.
